// File: rtl/muller_hs_pkg.sv
// Shared types and defaults for the 4-phase bundled-data initiator.
// Holds the FSM state encoding and the parameter defaults.
package muller_hs_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        REQ_HI,
        REQ_LO,
        ERR
    } hs_state_t;

    localparam int DEF_DATA_W      = 4;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_TIMEOUT     = 255;
    localparam int XFER_CNT_W      = 16;
    localparam int TIMER_W         = 8;

endpackage

// File: rtl/muller_hs_initiator_hs_sync.sv
// Multi-flop synchronizer for a single asynchronous bit.
// Ports: clock, rst_n (async, active-low), d (async in), q (synced out).
module hs_sync #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/muller_hs_initiator.sv
// 4-phase return-to-zero bundled-data initiator toward a C-element stage.
// Ports: clock, rst_n; in_valid/in_ready/in_data upstream; hs_req/hs_data/hs_ack
// handshake; clr_err; done pulse, sticky timeout_err, wrapping xfer_count.
module muller_hs_initiator
    import muller_hs_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int TIMEOUT     = DEF_TIMEOUT
) (
    input  logic                  clock,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_data,
    output logic                  hs_req,
    output logic [DATA_W-1:0]     hs_data,
    input  logic                  hs_ack,
    input  logic                  clr_err,
    output logic                  done,
    output logic                  timeout_err,
    output logic [XFER_CNT_W-1:0] xfer_count
);

    localparam logic [TIMER_W-1:0] TO_CNT = TIMER_W'(TIMEOUT);

    hs_state_t               state;
    logic                    ack_s;
    logic [TIMER_W-1:0]      timer;
    logic [TIMER_W-1:0]      timer_inc;
    logic                    phase_to;
    logic [XFER_CNT_W-1:0]   cnt_q;

    hs_sync #(
        .STAGES(SYNC_STAGES)
    ) u_ack_sync (
        .clock(clock),
        .rst_n(rst_n),
        .d    (hs_ack),
        .q    (ack_s)
    );

    // Timer counts cycles spent in the current wait phase; the phase
    // expires on the cycle that would bring it to TIMEOUT.
    assign timer_inc  = timer + TIMER_W'(1);
    assign phase_to   = (timer_inc == TO_CNT);
    assign xfer_count = cnt_q;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            in_ready    <= 1'b0;
            hs_req      <= 1'b0;
            hs_data     <= '0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
            cnt_q       <= '0;
            timer       <= '0;
        end else begin
            done <= 1'b0;
            // A timeout below overrides this clear in the same cycle.
            if (clr_err) begin
                timeout_err <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        hs_data  <= in_data;
                        in_ready <= 1'b0;
                        timer    <= '0;
                        state    <= SETUP;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                SETUP: begin
                    hs_req <= 1'b1;
                    timer  <= '0;
                    state  <= REQ_HI;
                end
                REQ_HI: begin
                    if (ack_s) begin
                        hs_req <= 1'b0;
                        timer  <= '0;
                        state  <= REQ_LO;
                    end else if (phase_to) begin
                        timeout_err <= 1'b1;
                        hs_req      <= 1'b0;
                        timer       <= '0;
                        state       <= ERR;
                    end else begin
                        timer <= timer_inc;
                    end
                end
                REQ_LO: begin
                    if (!ack_s) begin
                        done     <= 1'b1;
                        cnt_q    <= cnt_q + XFER_CNT_W'(1);
                        in_ready <= 1'b1;
                        timer    <= '0;
                        state    <= IDLE;
                    end else if (phase_to) begin
                        timeout_err <= 1'b1;
                        timer       <= '0;
                        state       <= ERR;
                    end else begin
                        timer <= timer_inc;
                    end
                end
                ERR: begin
                    // Wait for the stage to return to zero before reuse.
                    hs_req <= 1'b0;
                    if (!ack_s) begin
                        in_ready <= 1'b1;
                        timer    <= '0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    hs_req   <= 1'b0;
                    in_ready <= 1'b0;
                    timer    <= '0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule
